// File: rtl/hash_table_arbiter_if.sv
// Request/response bus between NUM_REQ clients, the arbiter and one hash-table port.
// slave = arbiter view, master = the surrounding clients and table.
interface hash_table_arbiter_if #(
   parameter int KEY_WIDTH  = 2,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REQ    = 3
);
   logic [NUM_REQ-1:0]            req_valid_i;
   logic [NUM_REQ-1:0]            req_ready_o;
   logic [3*NUM_REQ-1:0]          req_op_i;
   logic [KEY_WIDTH*NUM_REQ-1:0]  req_key_i;
   logic [DATA_WIDTH*NUM_REQ-1:0] req_data_i;

   logic                          tbl_valid_o;
   logic                          tbl_ready_i;
   logic [2:0]                    tbl_op_o;
   logic [KEY_WIDTH-1:0]          tbl_key_o;
   logic [DATA_WIDTH-1:0]         tbl_data_o;

   logic                          tbl_rsp_valid_i;
   logic                          tbl_rsp_ready_o;
   logic [DATA_WIDTH-1:0]         tbl_rsp_data_i;
   logic [3:0]                    tbl_rsp_flags_i;

   logic [NUM_REQ-1:0]            rsp_valid_o;
   logic [NUM_REQ-1:0]            rsp_ready_i;
   logic [DATA_WIDTH-1:0]         rsp_data_o;
   logic [3:0]                    rsp_flags_o;

   modport slave (
      input  req_valid_i, req_op_i, req_key_i, req_data_i, tbl_ready_i,
             tbl_rsp_valid_i, tbl_rsp_data_i, tbl_rsp_flags_i, rsp_ready_i,
      output req_ready_o, tbl_valid_o, tbl_op_o, tbl_key_o, tbl_data_o,
             tbl_rsp_ready_o, rsp_valid_o, rsp_data_o, rsp_flags_o
   );

   modport master (
      output req_valid_i, req_op_i, req_key_i, req_data_i, tbl_ready_i,
             tbl_rsp_valid_i, tbl_rsp_data_i, tbl_rsp_flags_i, rsp_ready_i,
      input  req_ready_o, tbl_valid_o, tbl_op_o, tbl_key_o, tbl_data_o,
             tbl_rsp_ready_o, rsp_valid_o, rsp_data_o, rsp_flags_o
   );
endinterface

// File: rtl/hash_table_arbiter.sv
// Round-robin sharing of one hash-table port between NUM_REQ requesters; an
// in-order ID FIFO steers each table response back to the requester that issued it.
module hash_table_arbiter #(
   parameter int KEY_WIDTH     = 2,
   parameter int DATA_WIDTH    = 32,
   parameter int NUM_REQ       = 3,
   parameter int ID_FIFO_DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           reset,
   hash_table_arbiter_if.slave            bus,
   output logic [$clog2(ID_FIFO_DEPTH):0] outstanding_o,
   output logic                           orphan_rsp_o
);
   localparam int IDW = $clog2(NUM_REQ);
   localparam int PW  = $clog2(ID_FIFO_DEPTH);
   localparam logic [PW:0]    FULL_CNT = (PW+1)'(ID_FIFO_DEPTH);
   localparam logic [IDW-1:0] LAST_ID  = IDW'(NUM_REQ - 1);

   typedef enum logic {S_IDLE, S_GRANT} state_t;

   state_t         r_state;
   logic [IDW-1:0] r_grant;
   logic [IDW-1:0] r_rr_ptr;
   logic [IDW-1:0] r_fifo [ID_FIFO_DEPTH];
   logic [PW-1:0]  r_wr_ptr;
   logic [PW-1:0]  r_rd_ptr;
   logic [PW:0]    r_count;
   logic           r_orphan;

   logic           w_any;
   logic [IDW-1:0] w_pick;
   logic [IDW-1:0] w_cand_id;
   int unsigned    w_cand;
   logic           w_push;
   logic           w_pop;
   logic           w_empty;
   logic [IDW-1:0] w_head;

   // First valid requester at or after the round-robin pointer, wrapping.
   always_comb begin
      w_any     = 1'b0;
      w_pick    = '0;
      w_cand    = 0;
      w_cand_id = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         w_cand    = (32'(r_rr_ptr) + k) % NUM_REQ;
         w_cand_id = IDW'(w_cand);
         if (!w_any && bus.req_valid_i[w_cand_id]) begin
            w_any  = 1'b1;
            w_pick = w_cand_id;
         end
      end
   end

   always_comb begin
      bus.tbl_valid_o = 1'b0;
      bus.req_ready_o = '0;
      if (r_state == S_GRANT) begin
         bus.tbl_valid_o          = bus.req_valid_i[r_grant];
         bus.req_ready_o[r_grant] = bus.tbl_ready_i;
      end
      bus.tbl_op_o   = bus.req_op_i[r_grant*3 +: 3];
      bus.tbl_key_o  = bus.req_key_i[r_grant*KEY_WIDTH +: KEY_WIDTH];
      bus.tbl_data_o = bus.req_data_i[r_grant*DATA_WIDTH +: DATA_WIDTH];
   end

   assign w_empty = (r_count == '0);
   assign w_head  = r_fifo[r_rd_ptr];

   always_comb begin
      bus.rsp_valid_o     = '0;
      bus.tbl_rsp_ready_o = 1'b0;
      if (!w_empty) begin
         bus.rsp_valid_o[w_head] = bus.tbl_rsp_valid_i;
         bus.tbl_rsp_ready_o     = bus.rsp_ready_i[w_head];
      end
   end

   assign bus.rsp_data_o  = bus.tbl_rsp_data_i;
   assign bus.rsp_flags_o = bus.tbl_rsp_flags_i;

   assign w_push = (r_state == S_GRANT) && bus.tbl_valid_o && bus.tbl_ready_i;
   assign w_pop  = bus.tbl_rsp_valid_i && bus.tbl_rsp_ready_o;

   // Grant decision uses the registered count, so a same-cycle pop never frees a slot early.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_grant  <= '0;
         r_rr_ptr <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_orphan <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any && (r_count < FULL_CNT)) begin
                  r_grant <= w_pick;
                  r_state <= S_GRANT;
               end
            end
            S_GRANT: begin
               if (w_push) begin
                  r_rr_ptr <= (r_grant == LAST_ID) ? '0 : r_grant + 1'b1;
                  r_state  <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase

         if (w_push) begin
            r_fifo[r_wr_ptr] <= r_grant;
            r_wr_ptr         <= r_wr_ptr + 1'b1;
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;

         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: ;
         endcase

         if (bus.tbl_rsp_valid_i && w_empty) r_orphan <= 1'b1;
      end
   end

   assign outstanding_o = r_count;
   assign orphan_rsp_o  = r_orphan;
endmodule

// File: doc/hash_table_arbiter.md
Name: hash_table_arbiter

Overview:
Shares one hash-table instance's ready/valid request port and response port between NUM_REQ independent requesters. Round-robin arbitration serialises requests (op, key, data) onto the table. An in-order ID FIFO records the issuing requester of each accepted request and steers each table response back to it. Sits between client logic (e.g. several AXI wrappers) and the table.

Parameters:
KEY_WIDTH, 2, key width in bits
DATA_WIDTH, 32, data/read-data width in bits
NUM_REQ, 3, number of requesters (2..8)
ID_FIFO_DEPTH, 4, max outstanding table requests (power of 2, >=2)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
req_valid_i  in  NUM_REQ  per-requester request valid
req_ready_o  out  NUM_REQ  per-requester request accept
req_op_i  in  3*NUM_REQ  per-requester op, one-hot {delete,write,read}, requester r at [3r+2:3r]
req_key_i  in  KEY_WIDTH*NUM_REQ  per-requester key, packed like req_op_i
req_data_i  in  DATA_WIDTH*NUM_REQ  per-requester write data, packed
tbl_valid_o  out  1  request valid to table
tbl_ready_i  in  1  table accepts request
tbl_op_o  out  3  op to table
tbl_key_o  out  KEY_WIDTH  key to table
tbl_data_o  out  DATA_WIDTH  data to table
tbl_rsp_valid_i  in  1  table response valid
tbl_rsp_ready_o  out  1  response accept to table
tbl_rsp_data_i  in  DATA_WIDTH  table read data
tbl_rsp_flags_i  in  4  {key_already_present, no_element_found, no_write_space, no_deletion_target}
rsp_valid_o  out  NUM_REQ  response valid, one-hot to owning requester
rsp_ready_i  in  NUM_REQ  per-requester response accept
rsp_data_o  out  DATA_WIDTH  broadcast read data (= tbl_rsp_data_i)
rsp_flags_o  out  4  broadcast flags (= tbl_rsp_flags_i)
outstanding_o  out  $clog2(ID_FIFO_DEPTH)+1  accepted requests awaiting response
orphan_rsp_o  out  1  sticky: table response seen with ID FIFO empty

Behaviour:
- Reset: state IDLE, grant=0, rr_ptr=0, FIFO empty, outstanding_o=0, orphan_rsp_o=0; all valid/ready outputs 0. Reset mid-transaction discards in-flight grant and IDs without completing handshakes.
- FSM IDLE: if any req_valid_i and outstanding_o<ID_FIFO_DEPTH, latch grant = first requester with valid at or after rr_ptr (wrapping NUM_REQ-1 -> 0); go GRANT. Else stay.
- FSM GRANT: tbl_valid_o = req_valid_i[grant]; tbl_op/key/data muxed from slice grant (combinational). req_ready_o[grant] = tbl_ready_i; other req_ready_o bits 0. On tbl_valid_o&&tbl_ready_i: push grant into FIFO, rr_ptr <= (grant+1) mod NUM_REQ, -> IDLE. Requesters hold valid and payload stable until accepted; if valid drops anyway, stay in GRANT with tbl_valid_o=0.
- Request latency: IDLE->handshake minimum 1 cycle after valid seen; max throughput 1 request per 2 cycles.
- In IDLE, tbl_valid_o=0 and req_ready_o=0.
- Response: head = FIFO head ID. If FIFO non-empty: rsp_valid_o[head]=tbl_rsp_valid_i, other bits 0; tbl_rsp_ready_o=rsp_ready_i[head]. Pop on tbl_rsp_valid_i&&tbl_rsp_ready_o. Responses return in request order.
- FIFO empty: rsp_valid_o=0, tbl_rsp_ready_o=0; tbl_rsp_valid_i=1 sets orphan_rsp_o (cleared only by reset).
- Push and pop in the same cycle: both take effect, outstanding_o unchanged. Full: IDLE does not grant; a pop that cycle does not enable a same-cycle grant (count evaluated from registered value).
- FIFO pointers wrap modulo ID_FIFO_DEPTH; outstanding_o = push count minus pop count, range 0..ID_FIFO_DEPTH.

Test Plan:
- Single req: requester 1 valid, op=3'b010, key=2'b10, data=0xDEADBEEF, tbl_ready_i=1 -> tbl_* carries those values 1 cycle later, req_ready_o=3'b010 for 1 cycle, outstanding_o=1; response data 0x1234 flags 0 -> rsp_valid_o=3'b010, outstanding_o=0.
- All 3 requesters valid continuously, table always ready -> grant order 0,1,2,0,1,2, one accept every 2 cycles.
- Fill: 4 accepted requests, no responses -> outstanding_o=4, req_ready_o stays 0 with pending valid; 1 response popped -> next grant issued, outstanding_o back to 4.
- Out-of-order backpressure: issue req from 2 then 0; rsp_ready_i=3'b001 only -> tbl_rsp_ready_o=0 (head is 2); assert rsp_ready_i[2] -> requester 2 gets response first, then 0.
- Orphan: tbl_rsp_valid_i=1 with FIFO empty -> tbl_rsp_ready_o=0, orphan_rsp_o=1 next cycle, stays until reset.
- Reset in GRANT with 2 outstanding -> next cycle all outputs 0, outstanding_o=0, rr_ptr=0 (requester 0 wins next).
